// File: rtl/tile_frame_drawer.sv
// Piano-tiles frame renderer: erases last frame's tiles, draws new ones.
// One pixel per cycle to the VGA adapter; optional full-screen clear.
module tile_frame_drawer #(
  parameter int NUM_ROWS = 6,
  parameter int NUM_COLS = 4,
  parameter int COL_W    = 3,
  parameter int TILE_W   = 80,
  parameter int TILE_H   = 40,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int OFFSET_W = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      clear,
  input  logic [OFFSET_W-1:0]       offset,
  input  logic [NUM_ROWS*COL_W-1:0] row_tile,
  input  logic [COLOR_W-1:0]        fg_color,
  input  logic [COLOR_W-1:0]        bg_color,
  output logic                      busy,
  output logic                      done,
  output logic                      vga_en,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [COLOR_W-1:0]        color
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int YH = Y_W + 1;
  localparam int TW = NUM_ROWS * COL_W;

  typedef enum logic [2:0] {
    IDLE, LATCH, ERASE, DRAW, CLEAR, FINISH
  } state_t;

  state_t state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [X_W-1:0] xo_q, xo_d;
  logic [Y_W-1:0] yo_q, yo_d;

  logic [TW-1:0]       cur_tile_q, prev_tile_q;
  logic [OFFSET_W-1:0] cur_off_q, prev_off_q;
  logic [COLOR_W-1:0]  fg_q, bg_q;
  logic                clr_q;

  logic               busy_q, busy_d, done_q, done_d;
  logic               en_q, en_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COLOR_W-1:0] col_q, col_d;

  function automatic logic [COL_W-1:0] row_code(
    input logic [TW-1:0] t, input logic [RW-1:0] r);
    return t[int'(r)*COL_W +: COL_W];
  endfunction

  function automatic logic [YH-1:0] row_y0(
    input logic [OFFSET_W-1:0] o, input logic [RW-1:0] r);
    return YH'(int'(r) * TILE_H + int'(o));
  endfunction

  function automatic logic row_empty(
    input logic [COL_W-1:0] c, input logic [YH-1:0] y0);
    return (c == '0) || (int'(c) > NUM_COLS) ||
           (int'(y0) >= SCREEN_H);
  endfunction

  function automatic logic [YH-1:0] row_h(input logic [YH-1:0] y0);
    int rem;
    rem = SCREEN_H - int'(y0);
    return YH'((rem < TILE_H) ? rem : TILE_H);
  endfunction

  function automatic logic [X_W-1:0] row_x0(input logic [COL_W-1:0] c);
    return X_W'((int'(c) - 1) * TILE_W);
  endfunction

  // geometry of the row being walked now, and of the row about to be shown
  logic [COL_W-1:0] code_c, code_n;
  logic [YH-1:0]    y0_c, y0_n, h_c;
  logic             empty_c, empty_n;
  logic [X_W-1:0]   x0_n;

  assign code_c  = row_code(state_q == ERASE ? prev_tile_q : cur_tile_q,
                            row_q);
  assign y0_c    = row_y0(state_q == ERASE ? prev_off_q : cur_off_q, row_q);
  assign empty_c = row_empty(code_c, y0_c);
  assign h_c     = row_h(y0_c);

  assign code_n  = row_code(state_d == ERASE ? prev_tile_q : cur_tile_q,
                            row_d);
  assign y0_n    = row_y0(state_d == ERASE ? prev_off_q : cur_off_q, row_d);
  assign empty_n = row_empty(code_n, y0_n);
  assign x0_n    = row_x0(code_n);

  // next state and raster iterators
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LATCH;
      end
      LATCH: begin
        row_d   = '0;
        xo_d    = '0;
        yo_d    = '0;
        state_d = clr_q ? CLEAR : ERASE;
      end
      ERASE, DRAW: begin
        if (empty_c || (xo_q == X_W'(TILE_W - 1) &&
            {1'b0, yo_q} == h_c - YH'(1))) begin
          xo_d = '0;
          yo_d = '0;
          if (row_q == RW'(NUM_ROWS - 1)) begin
            row_d   = '0;
            state_d = (state_q == ERASE) ? DRAW : FINISH;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else if (xo_q == X_W'(TILE_W - 1)) begin
          xo_d = '0;
          yo_d = yo_q + 1'b1;
        end else begin
          xo_d = xo_q + 1'b1;
        end
      end
      CLEAR: begin
        if (xo_q == X_W'(SCREEN_W - 1)) begin
          xo_d = '0;
          if (yo_q == Y_W'(SCREEN_H - 1)) begin
            yo_d    = '0;
            state_d = FINISH;
          end else begin
            yo_d = yo_q + 1'b1;
          end
        end else begin
          xo_d = xo_q + 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // registered outputs describe the step the FSM enters next cycle
  always_comb begin
    en_d   = 1'b0;
    x_d    = '0;
    y_d    = '0;
    col_d  = '0;
    busy_d = (state_d == LATCH) || (state_d == ERASE) ||
             (state_d == DRAW)  || (state_d == CLEAR);
    done_d = (state_d == FINISH);
    if ((state_d == ERASE || state_d == DRAW) && !empty_n) begin
      en_d  = 1'b1;
      x_d   = x0_n + xo_d;
      y_d   = Y_W'(y0_n + {1'b0, yo_d});
      col_d = (state_d == ERASE) ? bg_q : fg_q;
    end else if (state_d == CLEAR) begin
      en_d  = 1'b1;
      x_d   = xo_d;
      y_d   = yo_d;
      col_d = bg_q;
    end
  end

  // state, iterators and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
    end
  end

  // frame snapshot on start, and record of what is now on screen
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_tile_q  <= '0;
      cur_off_q   <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      clr_q       <= 1'b0;
      prev_tile_q <= '0;
      prev_off_q  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cur_tile_q <= row_tile;
        cur_off_q  <= (int'(offset) >= TILE_H) ?
                      OFFSET_W'(TILE_H - 1) : offset;
        fg_q       <= fg_color;
        bg_q       <= bg_color;
        clr_q      <= clear;
      end
      if (state_q == FINISH) begin
        if (clr_q) begin
          prev_tile_q <= '0;
        end else begin
          prev_tile_q <= cur_tile_q;
          prev_off_q  <= cur_off_q;
        end
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign vga_en = en_q;
  assign x      = x_q;
  assign y      = y_q;
  assign color  = col_q;

endmodule

// File: tb/tb_tile_frame_drawer.sv
// Self-checking bench for tile_frame_drawer against a per-frame
// expected pixel stream built from the tile geometry rules.
module tb_tile_frame_drawer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [5:0]  offset = '0;
  logic [17:0] row_tile = '0;
  logic [2:0]  fg_color = '0;
  logic [2:0]  bg_color = '0;
  logic        busy, done, vga_en;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  color;

  int nvec = 0;
  int nerr = 0;

  logic [17:0] m_prev_rt = '0;
  int          m_prev_off = 0;

  tile_frame_drawer dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear),
    .offset(offset), .row_tile(row_tile),
    .fg_color(fg_color), .bg_color(bg_color),
    .busy(busy), .done(done), .vga_en(vga_en),
    .x(x), .y(y), .color(color)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      if (nerr <= 20)
        $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pix(input int px, input int py,
                                      input logic [2:0] c);
    logic [8:0] xv;
    logic [7:0] yv;
    xv = 9'(px);
    yv = 8'(py);
    return {11'd0, 1'b1, xv, yv, c};
  endfunction

  // append one phase (erase or draw) of a tile frame to the stream
  task automatic add_phase(inout logic [31:0] q[$], input logic [17:0] rt,
                           input int off, input logic [2:0] c);
    for (int r = 0; r < 6; r++) begin
      int code, y0, h;
      code = int'(rt[r*3 +: 3]);
      y0   = r * 40 + off;
      if (code == 0 || code > 4 || y0 >= 240) begin
        q.push_back(32'd0);
      end else begin
        h = (240 - y0 < 40) ? 240 - y0 : 40;
        for (int yy = 0; yy < h; yy++)
          for (int xx = 0; xx < 80; xx++)
            q.push_back(pix((code - 1) * 80 + xx, y0 + yy, c));
      end
    end
  endtask

  task automatic run_frame(input logic clr, input logic [5:0] off,
                           input logic [17:0] rt, input logic [2:0] fg,
                           input logic [2:0] bg, input logic hold,
                           input int abort_at, output int npx);
    logic [31:0] q[$];
    int coff;
    npx  = 0;
    coff = (int'(off) >= 40) ? 39 : int'(off);
    if (clr) begin
      for (int yy = 0; yy < 240; yy++)
        for (int xx = 0; xx < 320; xx++)
          q.push_back(pix(xx, yy, bg));
    end else begin
      add_phase(q, m_prev_rt, m_prev_off, bg);
      add_phase(q, rt, coff, fg);
    end
    start = 1'b1;
    clear = clr;
    offset = off;
    row_tile = rt;
    fg_color = fg;
    bg_color = bg;
    tick();
    chk("latch_busy", 32'(busy), 32'd1);
    chk("latch_en", 32'(vga_en), 32'd0);
    if (hold) begin
      clear = ~clr;
      offset = ~off;
      row_tile = ~rt;
      fg_color = ~fg;
      bg_color = ~bg;
    end else begin
      start = 1'b0;
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", {vga_en, x, y, color}, 32'd0);
        reset = 1'b0;
        m_prev_rt = '0;
        m_prev_off = 0;
        return;
      end
      if (i == q.size() - 1) start = 1'b0;
      tick();
      chk("en", 32'(vga_en), 32'(q[i][20]));
      if (q[i][20]) begin
        chk("pix", {12'd0, x, y, color}, {12'd0, q[i][19:0]});
        npx++;
      end
      if (i == 0 || i == q.size() - 1)
        chk("busy", 32'(busy), 32'd1);
    end
    tick();
    chk("done", {done, busy, vga_en}, 32'b100);
    tick();
    chk("done_1cyc", {done, busy}, 32'b00);
    if (clr) begin
      m_prev_rt = '0;
    end else begin
      m_prev_rt = rt;
      m_prev_off = coff;
    end
  endtask

  initial begin
    int n;
    logic [17:0] rt;
    repeat (3) tick();
    chk("reset", {busy, done, vga_en, x, y, color}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle", {busy, done, vga_en}, 32'd0);

    run_frame(1'b1, 6'd0, 18'd0, 3'd7, 3'd0, 1'b0, -1, n);
    chk("clr_px", 32'(n), 32'd76800);

    run_frame(1'b0, 6'd0, 18'd1, 3'd7, 3'd0, 1'b0, -1, n);
    chk("first_px", 32'(n), 32'd3200);

    run_frame(1'b0, 6'd10, 18'd0, 3'd7, 3'd2, 1'b0, -1, n);
    chk("erase_px", 32'(n), 32'd3200);

    rt = 18'd4 << 15;
    run_frame(1'b0, 6'd30, rt, 3'd5, 3'd1, 1'b0, -1, n);
    chk("clip_px", 32'(n), 32'd800);

    run_frame(1'b0, 6'd45, rt, 3'd6, 3'd1, 1'b0, -1, n);
    chk("clamp_px", 32'(n), 32'd880);

    for (int f = 0; f < 2; f++) begin
      logic [2:0] em;
      rt = '0;
      for (int r = 0; r < 5; r++) begin
        em = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
        rt[r*3 +: 3] = em;
      end
      rt[15 +: 3] = 3'($urandom_range(0, 7));
      run_frame(1'b0, 6'($urandom_range(0, 63)), rt,
                3'($urandom), 3'($urandom), 1'b0, -1, n);
    end

    rt = 18'd1 << 15;
    run_frame(1'b0, 6'd39, rt, 3'd3, 3'd4, 1'b1, -1, n);
    chk("idle_after", {busy, done}, 32'd0);
    tick();
    chk("no_restart", {busy, done, vga_en}, 32'd0);

    run_frame(1'b0, 6'd5, 18'd3, 3'd2, 3'd0, 1'b0,
              n + 5 + 6 + 100, n);
    tick();
    chk("post_rst", {busy, done, vga_en}, 32'd0);

    run_frame(1'b0, 6'd0, 18'd0, 3'd1, 3'd0, 1'b0, -1, n);
    chk("rst_empty_px", 32'(n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tile_frame_drawer.md
# tile_frame_drawer

Parametrised frame renderer for the piano-tiles display. Each frame it erases every tile rectangle drawn in the previous frame, then draws every tile at the new scroll offset. It emits one pixel per cycle to the VGA adapter and supports a full-screen clear mode. It sits between the game-state controller, which supplies the tile columns, scroll offset and start, and the VGA adapter, which receives the x, y, colour and plot outputs.

## Interface
Parameters:
- NUM_ROWS, 6: number of tile rows on screen
- NUM_COLS, 4: lanes per row
- COL_W, 3: bits per row column code
- TILE_W, 80: tile width in pixels
- TILE_H, 40: tile height in pixels
- SCREEN_W, 320: screen width in pixels
- SCREEN_H, 240: screen height in pixels
- X_W, 9 / Y_W, 8: coordinate widths
- COLOR_W, 3: colour width
- OFFSET_W, 6: scroll offset width

Ports:
- clock, in, 1: single clock
- reset, in, 1: synchronous, active-high
- start, in, 1: frame request; sampled only in IDLE
- clear, in, 1: sampled together with start; 1 selects full-screen fill with bg_color
- offset, in, OFFSET_W: vertical scroll of all rows
- row_tile, in, NUM_ROWS*COL_W: row r column code at [r*COL_W +: COL_W]; 0 means empty, 1..NUM_COLS means lane, any larger value means empty
- fg_color, in, COLOR_W: tile colour
- bg_color, in, COLOR_W: background colour
- busy, out, 1: frame in progress
- done, out, 1: one-cycle pulse at frame end
- vga_en, out, 1: plot strobe
- x, out, X_W: pixel x
- y, out, Y_W: pixel y
- color, out, COLOR_W: pixel colour

## Operation
- States: IDLE, LATCH, ERASE, DRAW, CLEAR, FINISH.
- IDLE with start=1:
  - Go to LATCH.
  - Snapshot offset, row_tile, fg_color, bg_color and clear into internal registers.
  - Inputs are ignored from then until the next IDLE.
- Offset clamp: an offset of TILE_H or more is clamped to TILE_H-1.
- Rectangle geometry for row r with code c:
  - x0 = (c-1)*TILE_W, width TILE_W.
  - y0 = r*TILE_H + offset, computed Y_W+1 bits wide.
  - Height h = min(TILE_H, SCREEN_H-y0).
  - If y0 >= SCREEN_H the row is treated as empty.
- LATCH -> ERASE, or -> CLEAR when clear=1.
- ERASE:
  - Rows 0..NUM_ROWS-1 in order, using prev_tile/prev_offset, i.e. the snapshot of the last completed frame.
  - Each pixel is painted bg_color.
- DRAW:
  - Rows 0..NUM_ROWS-1 in order, using the current snapshot.
  - Each pixel is painted fg_color.
  - All erases complete before any draw.
- Raster order within a rectangle: x increments fastest from x0 to x0+TILE_W-1, then y increments from y0 to y0+h-1.
- Empty row slot: consumes exactly 1 cycle with vga_en=0.
- No idle cycles are inserted between rectangles, between rows, or between the ERASE and DRAW phases.
- CLEAR:
  - Fills x 0..SCREEN_W-1 by y 0..SCREEN_H-1 in raster order with bg_color.
  - Sets all prev_tile entries to empty.
  - Skips ERASE and DRAW.
- FINISH:
  - done=1 and busy=0 in the same cycle.
  - Non-clear frames copy the current snapshot into prev_tile/prev_offset.
  - Then return to IDLE.
- Reset, at any time including mid-frame:
  - State goes to IDLE.
  - busy, done, vga_en, x, y and color all go to 0.
  - prev_tile entries become empty and prev_offset becomes 0.
  - Partial frames are not resumed. Screen consistency after reset is the controller's job, via a clear frame.

## Timing
- Outputs are registered; x, y and color are valid whenever vga_en=1.
- start sampled high at cycle k:
  - busy=1 from k+1.
  - The first pixel or skip slot is at k+2.
- Emission phase length = P + Z cycles, where P is the pixel count and Z is the number of empty row slots, both phases included.
  - Phase spans cycles k+2 .. k+1+P+Z.
  - done pulse at k+2+P+Z.
- Clear frame: P = SCREEN_W*SCREEN_H and Z=0.
- done lasts exactly 1 cycle.
- A new start is accepted no earlier than the cycle after done.
- start held high continuously runs back-to-back frames separated by that 1 IDLE cycle.
- vga_en is 0 in IDLE, LATCH and FINISH.

## Test plan
- Clear: reset, then start with clear=1, bg=3'b000 at cycle k.
  - 76800 vga_en cycles, first (0,0), last (319,239).
  - done at k+76802.
- First frame: after reset, row_tile row0=1 and others 0, offset=0, fg=3'b111.
  - 6 erase skip cycles, then 3200 pixels x 0..79 y 0..39 colour 7, then 5 skip cycles.
  - done at k+3213.
- Erase of previous frame: next start with all rows empty, offset=10.
  - 3200 bg pixels at x 0..79 y 0..39 (previous offset 0), then 5 erase skips and 6 draw skips.
  - done at k+3213.
- Clipping and clamp: row5=4, offset=30.
  - Draw rectangle x 240..319, y 230..239, 800 pixels, last (319,239).
  - Repeat with offset=45: clamped to 39, rectangle y 239..239, 80 pixels.
- Busy and reset: assert start again mid-frame; it is ignored and done pulses only once.
  - Assert reset mid-draw: the next cycle has vga_en=0, busy=0 and all outputs 0.
  - Then start with all rows empty: 12 skip cycles, no pixels, done at k+14.
